// File: rtl/turn_signal_conditioner.sv
// turn_signal_conditioner: synchronizes and debounces the turn switches,
// paces the light sequence with a step tick, and holds CL between steps.
module turn_signal_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 5,
    parameter int DB_W            = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int TK_W            = $clog2(TICK_DIV)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       left_raw,
    input  logic       right_raw,
    output logic [1:0] CL,
    output logic       step,
    output logic       cl_change
);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_LAST = TK_W'(TICK_DIV - 1);

    // Bit 1 is the left channel, bit 0 the right channel.
    logic [1:0]      raw;
    logic [1:0]      s1_q;
    logic [1:0]      s2_q;
    logic [1:0]      db_q;
    logic [1:0]      db_d;
    logic [DB_W-1:0] cnt_q [2];
    logic [DB_W-1:0] cnt_d [2];
    logic [TK_W-1:0] tk_q;
    logic [TK_W-1:0] tk_d;
    logic            load;
    logic [1:0]      cl_q;
    logic [1:0]      cl_d;
    logic            step_q;
    logic            step_d;
    logic            chg_q;
    logic            chg_d;

    assign raw = {left_raw, right_raw};

    // Debounce: count consecutive disagreeing samples; any agreement restarts.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // Free-running step divider and step-aligned command capture.
    always_comb begin
        load   = (tk_q == TK_LAST);
        tk_d   = load ? '0 : tk_q + TK_W'(1);
        cl_d   = load ? db_q : cl_q;
        step_d = load;
        chg_d  = load && (db_q != cl_q);
    end

    // All state registers; reset discards debounce progress and tick phase.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            db_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            tk_q     <= '0;
            cl_q     <= '0;
            step_q   <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            s1_q     <= raw;
            s2_q     <= s1_q;
            db_q     <= db_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            tk_q     <= tk_d;
            cl_q     <= cl_d;
            step_q   <= step_d;
            chg_q    <= chg_d;
        end
    end

    assign CL        = cl_q;
    assign step      = step_q;
    assign cl_change = chg_q;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// tb_turn_signal_conditioner: directed checks of sync/debounce latency,
// step cadence, step-aligned CL updates and asynchronous reset.
module tb_turn_signal_conditioner;

    logic       clk;
    logic       reset;
    logic       left_raw;
    logic       right_raw;
    logic [1:0] CL;
    logic       step;
    logic       cl_change;

    int         total;
    int         passed;
    int         e;
    logic [1:0] cl_exp;

    turn_signal_conditioner dut (
        .clk       (clk),
        .reset     (reset),
        .left_raw  (left_raw),
        .right_raw (right_raw),
        .CL        (CL),
        .step      (step),
        .cl_change (cl_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [1:0] obs,
                       input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s edge=%0d observed=%b expected=%b",
                    tag, e, obs, exp);
    endtask

    // Advance n edges; CL is expected to take cl_new at edge chg_at
    // (0 = no change) with a cl_change pulse there; steps every 5 edges.
    task automatic advance(input int n, input logic [1:0] cl_new,
                           input int chg_at);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            e++;
            if (e == chg_at) cl_exp = cl_new;
            chk("step", {1'b0, step}, {1'b0, logic'((e % 5) == 0)});
            chk("CL", CL, cl_exp);
            chk("cl_change", {1'b0, cl_change}, {1'b0, logic'(e == chg_at)});
        end
    endtask

    initial begin
        logic [6:0] pat;
        clk       = 1'b0;
        reset     = 1'b1;
        left_raw  = 1'b1;
        right_raw = 1'b1;
        total     = 0;
        passed    = 0;
        e         = 0;
        cl_exp    = 2'b00;

        // Reset held for 3 clocks with both raws high.
        #1 reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_CL", CL, 2'b00);
            chk("rst_step", {1'b0, step}, 2'b00);
            chk("rst_chg", {1'b0, cl_change}, 2'b00);
        end

        // Clean left press from release: CL=10 at step 10, held at 15.
        left_raw  = 1'b1;
        right_raw = 1'b0;
        reset     = 1'b1;
        e         = 0;
        advance(16, 2'b10, 10);

        // Release left: db falls after edge 22, seen at step 25.
        left_raw = 1'b0;
        advance(9, 2'b00, 25);

        // 3-clock right glitch is rejected across 4 steps.
        right_raw = 1'b1;
        advance(3, 2'b00, 0);
        right_raw = 1'b0;
        advance(17, 2'b00, 0);

        // Bounce 1,1,0,1,1,1,1: db rises after edge 54, CL=10 at step 55.
        pat = 7'b1111011;
        for (int i = 0; i < 7; i++) begin
            left_raw = pat[i];
            advance(1, 2'b10, 55);
        end
        advance(8, 2'b10, 55);

        // Back to idle.
        left_raw = 1'b0;
        advance(10, 2'b00, 70);

        // Hazard: both together go 00 -> 11 directly, then back to 00.
        left_raw  = 1'b1;
        right_raw = 1'b1;
        advance(10, 2'b11, 80);
        left_raw  = 1'b0;
        right_raw = 1'b0;
        advance(10, 2'b00, 90);

        // Reach CL=10 with tick counter at 3.
        left_raw = 1'b1;
        advance(10, 2'b10, 100);
        advance(3, 2'b10, 0);

        // Short reset between edges clears CL at once.
        reset = 1'b0;
        #2;
        chk("midrst_CL", CL, 2'b00);
        chk("midrst_step", {1'b0, step}, 2'b00);
        chk("midrst_chg", {1'b0, cl_change}, 2'b00);
        reset  = 1'b1;
        e      = 0;
        cl_exp = 2'b00;

        // Phase restarted; CL=10 again only at step 10.
        advance(15, 2'b10, 10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
